// File: rtl/wb2axi4lite_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : wb2axi4lite_pkg
//  Purpose  : Shared types and constants for the Wishbone-to-AXI4-Lite bridge:
//             bridge FSM state encoding, AXI response codes, protection value
//             and a response classification helper.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package wb2axi4lite_pkg;

  // Bridge FSM states. Only one transfer is ever outstanding.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR      = 3'd1,
    ST_WR_RESP = 3'd2,
    ST_RD      = 3'd3,
    ST_RD_RESP = 3'd4
  } state_t;

  // AXI response codes
  localparam logic [1:0] c_RESP_OKAY   = 2'b00;
  localparam logic [1:0] c_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] c_RESP_SLVERR = 2'b10;
  localparam logic [1:0] c_RESP_DECERR = 2'b11;

  // Unprivileged, secure, data access
  localparam logic [2:0] c_PROT_DEFAULT = 3'b000;

  // OKAY/EXOKAY complete normally; SLVERR/DECERR are reported as bus errors.
  function automatic logic resp_is_err(input logic [1:0] resp);
    logic v_err;
    case (resp)
      c_RESP_OKAY, c_RESP_EXOKAY:   v_err = 1'b0;
      c_RESP_SLVERR, c_RESP_DECERR: v_err = 1'b1;
      default:                      v_err = 1'b0;
    endcase
    return v_err;
  endfunction

endpackage
`default_nettype wire

// File: rtl/wb2axi4lite.sv
`default_nettype none
// ============================================================================
//  Module   : wb2axi4lite
//  Purpose  : Bridge from a pipelined Wishbone slave port to an AXI4-Lite
//             master port. One transfer outstanding at a time.
//  Ports    :
//    aclk, areset              clock, synchronous active-high reset
//    wb_cyc_i/stb_i/we_i       Wishbone request qualifiers
//    wb_adr_i/sel_i/dat_i      Wishbone address, byte selects, write data
//    wb_ack_o/err_o/stall_o    Wishbone completion and flow control
//    wb_dat_o                  Wishbone read data (valid with wb_ack_o)
//    aw*/w*/b*/ar*/r*          AXI4-Lite master channels
//  Options  : define WB2AXI4LITE_TIMEOUT_EN to enable a per-phase response
//             timeout of TIMEOUT cycles that ends the transfer with wb_err_o.
//  Revision : 1.0 - initial release
// ============================================================================
module wb2axi4lite
  import wb2axi4lite_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                  aclk,
  input  logic                  areset,
  // Wishbone slave
  input  logic                  wb_cyc_i,
  input  logic                  wb_stb_i,
  input  logic                  wb_we_i,
  input  logic [ADDR_WIDTH-1:0] wb_adr_i,
  input  logic [3:0]            wb_sel_i,
  input  logic [31:0]           wb_dat_i,
  output logic                  wb_ack_o,
  output logic                  wb_err_o,
  output logic                  wb_stall_o,
  output logic [31:0]           wb_dat_o,
  // AXI4-Lite write address
  output logic                  awvalid,
  input  logic                  awready,
  output logic [ADDR_WIDTH-1:0] awaddr,
  output logic [2:0]            awprot,
  // AXI4-Lite write data
  output logic                  wvalid,
  input  logic                  wready,
  output logic [31:0]           wdata,
  output logic [3:0]            wstrb,
  // AXI4-Lite write response
  input  logic                  bvalid,
  output logic                  bready,
  input  logic [1:0]            bresp,
  // AXI4-Lite read address
  output logic                  arvalid,
  input  logic                  arready,
  output logic [ADDR_WIDTH-1:0] araddr,
  output logic [2:0]            arprot,
  // AXI4-Lite read data
  input  logic                  rvalid,
  output logic                  rready,
  input  logic [31:0]           rdata,
  input  logic [1:0]            rresp
);

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_adr;
  logic [31:0]           r_dat;
  logic [3:0]            r_sel;
  logic [31:0]           r_rdata;
  logic                  r_awvalid;
  logic                  r_wvalid;
  logic                  r_bready;
  logic                  r_arvalid;
  logic                  r_rready;
  logic                  r_ack;
  logic                  r_err;
  logic                  r_stall;
  // Set once the master drops wb_cyc_i during a transfer; the AXI side still
  // runs to completion but the result is not reported to Wishbone.
  logic                  r_abort;

  // A write address/data phase counts as done if it already completed or
  // completes this cycle; both must be done to leave ST_WR.
  logic w_aw_done;
  logic w_w_done;
  logic w_deliver;

  assign w_aw_done = !r_awvalid || awready;
  assign w_w_done  = !r_wvalid  || wready;
  assign w_deliver = wb_cyc_i && !r_abort;

`ifdef WB2AXI4LITE_TIMEOUT_EN
  localparam int                 c_TMO_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [c_TMO_W-1:0] c_TMO_MAX = c_TMO_W'(TIMEOUT - 1);

  logic [c_TMO_W-1:0] r_tmo_cnt;
  logic               w_advance;

  // High on any cycle the FSM leaves its current busy state; the timeout
  // counter restarts for every phase so each handshake gets TIMEOUT cycles.
  assign w_advance = ((r_state == ST_WR)      && w_aw_done && w_w_done) ||
                     ((r_state == ST_WR_RESP) && bvalid)                ||
                     ((r_state == ST_RD)      && arready)               ||
                     ((r_state == ST_RD_RESP) && rvalid);
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT != 0);
`endif

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_state   <= ST_IDLE;
      r_adr     <= '0;
      r_dat     <= '0;
      r_sel     <= '0;
      r_rdata   <= '0;
      r_awvalid <= 1'b0;
      r_wvalid  <= 1'b0;
      r_bready  <= 1'b0;
      r_arvalid <= 1'b0;
      r_rready  <= 1'b0;
      r_ack     <= 1'b0;
      r_err     <= 1'b0;
      r_stall   <= 1'b0;
      r_abort   <= 1'b0;
`ifdef WB2AXI4LITE_TIMEOUT_EN
      r_tmo_cnt <= '0;
`endif
    end else begin
      // Completion strobes are single-cycle pulses.
      r_ack <= 1'b0;
      r_err <= 1'b0;

      if ((r_state != ST_IDLE) && !wb_cyc_i) begin
        r_abort <= 1'b1;
      end

      case (r_state)
        ST_IDLE: begin
          if (wb_cyc_i && wb_stb_i) begin
            r_adr   <= wb_adr_i;
            r_dat   <= wb_dat_i;
            r_sel   <= wb_sel_i;
            r_abort <= 1'b0;
            r_stall <= 1'b1;
            if (wb_we_i) begin
              r_state   <= ST_WR;
              r_awvalid <= 1'b1;
              r_wvalid  <= 1'b1;
            end else begin
              r_state   <= ST_RD;
              r_arvalid <= 1'b1;
            end
          end
        end

        ST_WR: begin
          // Address and data channels retire independently.
          if (r_awvalid && awready) begin
            r_awvalid <= 1'b0;
          end
          if (r_wvalid && wready) begin
            r_wvalid <= 1'b0;
          end
          if (w_aw_done && w_w_done) begin
            r_state  <= ST_WR_RESP;
            r_bready <= 1'b1;
          end
        end

        ST_WR_RESP: begin
          if (bvalid) begin
            r_bready <= 1'b0;
            r_ack    <= w_deliver && !resp_is_err(bresp);
            r_err    <= w_deliver &&  resp_is_err(bresp);
            r_stall  <= 1'b0;
            r_state  <= ST_IDLE;
          end
        end

        ST_RD: begin
          if (arready) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= ST_RD_RESP;
          end
        end

        ST_RD_RESP: begin
          if (rvalid) begin
            r_rready <= 1'b0;
            r_rdata  <= rdata;
            r_ack    <= w_deliver && !resp_is_err(rresp);
            r_err    <= w_deliver &&  resp_is_err(rresp);
            r_stall  <= 1'b0;
            r_state  <= ST_IDLE;
          end
        end

        default: begin
          r_state <= ST_IDLE;
          r_stall <= 1'b0;
        end
      endcase

`ifdef WB2AXI4LITE_TIMEOUT_EN
      // A genuine handshake in the same cycle wins over an expiring count.
      if ((r_state == ST_IDLE) || w_advance) begin
        r_tmo_cnt <= '0;
      end else if (r_tmo_cnt == c_TMO_MAX) begin
        r_tmo_cnt <= '0;
        r_state   <= ST_IDLE;
        r_awvalid <= 1'b0;
        r_wvalid  <= 1'b0;
        r_bready  <= 1'b0;
        r_arvalid <= 1'b0;
        r_rready  <= 1'b0;
        r_stall   <= 1'b0;
        r_ack     <= 1'b0;
        r_err     <= w_deliver;
      end else begin
        r_tmo_cnt <= r_tmo_cnt + 1'b1;
      end
`endif
    end
  end

  assign wb_ack_o   = r_ack;
  assign wb_err_o   = r_err;
  assign wb_stall_o = r_stall;
  assign wb_dat_o   = r_rdata;

  assign awvalid = r_awvalid;
  assign awaddr  = r_adr;
  assign awprot  = c_PROT_DEFAULT;
  assign wvalid  = r_wvalid;
  assign wdata   = r_dat;
  assign wstrb   = r_sel;
  assign bready  = r_bready;
  assign arvalid = r_arvalid;
  assign araddr  = r_adr;
  assign arprot  = c_PROT_DEFAULT;
  assign rready  = r_rready;

endmodule
`default_nettype wire
